// File: rtl/wb2axi_pkg.sv
// Shared Wishbone cycle/burst encodings and target FSM states for the AXI-to-WB bridge blocks.
package wb2axi_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } tgt_state_t;

endpackage

// File: rtl/wb_tx_sram_target_if.sv
// Wishbone B4 bus between the bridge's WB_TX master port and a target.
interface wb_tx_sram_target_if #(
  parameter int unsigned WB_ADR_W = 32,
  parameter int unsigned WB_DAT_W = 32,
  parameter int unsigned WB_SEL_W = 4,
  parameter int unsigned WB_CTI_W = 3,
  parameter int unsigned WB_BTE_W = 2
);
  logic                WB_CYC_I;
  logic                WB_STB_I;
  logic                WB_WE_I;
  logic [WB_ADR_W-1:0] WB_ADR_I;
  logic [WB_DAT_W-1:0] WB_DAT_I;
  logic [WB_SEL_W-1:0] WB_SEL_I;
  logic [WB_CTI_W-1:0] WB_CTI_I;
  logic [WB_BTE_W-1:0] WB_BTE_I;
  logic [WB_DAT_W-1:0] WB_DAT_O;
  logic                WB_ACK_O;
  logic                WB_ERR_O;

  modport master (
    output WB_CYC_I, WB_STB_I, WB_WE_I, WB_ADR_I, WB_DAT_I, WB_SEL_I, WB_CTI_I, WB_BTE_I,
    input  WB_DAT_O, WB_ACK_O, WB_ERR_O
  );

  modport slave (
    input  WB_CYC_I, WB_STB_I, WB_WE_I, WB_ADR_I, WB_DAT_I, WB_SEL_I, WB_CTI_I, WB_BTE_I,
    output WB_DAT_O, WB_ACK_O, WB_ERR_O
  );
endinterface

// File: rtl/wb_burst_addr_gen.sv
// Next word pointer for a Wishbone burst: linear wraps at the top of memory, wrapN stays in its N-word block.
module wb_burst_addr_gen
  import wb2axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] ptr_i,
  input  bte_e              bte_i,
  output logic [ADDR_W-1:0] next_ptr_c
);
  logic [ADDR_W-1:0] mask_c;
  logic [ADDR_W-1:0] inc_c;

  // Bits under the mask advance; the rest of the pointer is frozen.
  always_comb begin
    mask_c = '1;
    case (bte_i)
      WRAP4:   mask_c = ADDR_W'(3);
      WRAP8:   mask_c = ADDR_W'(7);
      WRAP16:  mask_c = ADDR_W'(15);
      default: mask_c = '1;
    endcase
  end

  assign inc_c      = ptr_i + ADDR_W'(1);
  assign next_ptr_c = (ptr_i & ~mask_c) | (inc_c & mask_c);
endmodule

// File: rtl/wb_tx_sram_target.sv
// Wishbone B4 target backed by a flop memory; serves classic and CTI/BTE bursts, errors on window miss or misalignment.
module wb_tx_sram_target
  import wb2axi_pkg::*;
#(
  parameter int unsigned         WB_ADR_W   = 32,
  parameter int unsigned         WB_DAT_W   = 32,
  parameter int unsigned         WB_SEL_W   = 4,
  parameter int unsigned         WB_CTI_W   = 3,
  parameter int unsigned         WB_BTE_W   = 2,
  parameter int unsigned         MEM_ADDR_W = 8,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                wb_clk,
  input  logic                wb_resetn,
  wb_tx_sram_target_if.slave  wb,
  output logic [15:0]         ERR_CNT
);
  localparam int unsigned MEM_DEPTH = 2 ** MEM_ADDR_W;
  localparam int unsigned TAG_LSB   = MEM_ADDR_W + 2;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  tgt_state_t            state_q, state_d;
  logic [MEM_ADDR_W-1:0] ptr_q, ptr_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [WB_DAT_W-1:0]   dat_q, dat_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [WB_DAT_W-1:0]   mem_q [MEM_DEPTH];

  logic [MEM_ADDR_W-1:0] idx_c, ptr_next_c;
  logic [WB_CTI_W-1:0]   cti_c;
  logic [WB_BTE_W-1:0]   bte_c;
  logic [WB_DAT_W-1:0]   wdata_c;
  logic                  req_c, hit_c, ack_c, err_c, we_c;

  assign req_c = wb.WB_CYC_I & wb.WB_STB_I;
  assign idx_c = wb.WB_ADR_I[TAG_LSB-1:2];
  assign cti_c = wb.WB_CTI_I;
  assign bte_c = wb.WB_BTE_I;
  assign hit_c = (wb.WB_ADR_I[WB_ADR_W-1:TAG_LSB] == BASE_ADDR[WB_ADR_W-1:TAG_LSB]) &&
                 (wb.WB_ADR_I[1:0] == 2'b00);

  // Terminations are masked while reset is sampled so an abandoned beat is neither acked nor written.
  assign ack_c = ack_q & req_c & wb_resetn;
  assign err_c = err_q & req_c & wb_resetn;
  assign we_c  = ack_c & wb.WB_WE_I;

  assign wb.WB_ACK_O = ack_c;
  assign wb.WB_ERR_O = err_c;
  assign wb.WB_DAT_O = dat_q;
  assign ERR_CNT     = err_cnt_q;

  wb_burst_addr_gen #(
    .ADDR_W (MEM_ADDR_W)
  ) u_addr_gen (
    .ptr_i      (ptr_q),
    .bte_i      (bte_e'(bte_c)),
    .next_ptr_c (ptr_next_c)
  );

  always_comb begin
    wdata_c = mem_q[ptr_q];
    for (int unsigned i = 0; i < WB_SEL_W; i++) begin
      if (wb.WB_SEL_I[i]) wdata_c[8*i +: 8] = wb.WB_DAT_I[8*i +: 8];
    end
  end

  // Next-state: hit/miss latched once per burst; read data is prefetched for the beat that follows.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ack_d     = ack_q;
    err_d     = err_q;
    dat_d     = dat_q;
    err_cnt_d = err_cnt_q;

    if (err_c && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          state_d = ACTIVE;
          ptr_d   = idx_c;
          ack_d   = hit_c;
          err_d   = !hit_c;
          dat_d   = hit_c ? mem_q[idx_c] : '0;
        end
      end
      ACTIVE: begin
        if (!wb.WB_CYC_I) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end else if (ack_c || err_c) begin
          if (cti_c == CTI_INCR) begin
            ptr_d = ptr_next_c;
            dat_d = err_q ? '0 : mem_q[ptr_next_c];
          end else begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_resetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Backing store is not reset.
  always_ff @(posedge wb_clk) begin
    if (we_c) mem_q[ptr_q] <= wdata_c;
  end
endmodule

// File: tb/tb_wb_tx_sram_target.sv
// Bench for wb_tx_sram_target: directed scenarios plus random bursts against a word-array reference model.
module tb_wb_tx_sram_target;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_mem [256];
  int unsigned model_err;
  logic [31:0] beat_dat  [256];
  logic [31:0] rd_got    [256];

  wb_tx_sram_target_if bus ();

  wb_tx_sram_target dut (
    .wb_clk    (clk),
    .wb_resetn (rst_n),
    .wb        (bus),
    .ERR_CNT   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Next word of a burst: stay inside the aligned block of the burst length.
  function automatic int unsigned next_word(input int unsigned idx, input logic [1:0] bte);
    int unsigned len;
    case (bte)
      2'd1:    len = 4;
      2'd2:    len = 8;
      2'd3:    len = 16;
      default: len = 256;
    endcase
    return (idx / len) * len + (idx + 1) % len;
  endfunction

  task automatic drive_beat(input logic we_i, input logic [31:0] adr_i, input int unsigned idx,
                            input logic [1:0] bte_i, input logic [3:0] sel_i, input int k, input int n);
    bus.WB_CYC_I = 1'b1;
    bus.WB_STB_I = 1'b1;
    bus.WB_WE_I  = we_i;
    bus.WB_ADR_I = {adr_i[31:10], 8'(idx), adr_i[1:0]};
    bus.WB_DAT_I = beat_dat[k];
    bus.WB_SEL_I = sel_i;
    bus.WB_BTE_I = bte_i;
    if (n == 1)          bus.WB_CTI_I = 3'b000;
    else if (k == n - 1) bus.WB_CTI_I = 3'b111;
    else                 bus.WB_CTI_I = 3'b010;
  endtask

  // One burst of n beats; optional master-wait gap after beat gap_after, optional reset at beat rst_at.
  task automatic burst(input string tag, input logic we_i, input logic [31:0] adr_i, input logic [1:0] bte_i,
                       input logic [3:0] sel_i, input int n, input int gap_after, input int gap_len,
                       input int rst_at);
    int unsigned idx;
    logic        hit;
    logic [31:0] mask;
    hit  = (adr_i[31:10] == 22'd0) && (adr_i[1:0] == 2'b00);
    idx  = 32'(adr_i[9:2]);
    mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    @(posedge clk); #1;
    drive_beat(we_i, adr_i, idx, bte_i, sel_i, 0, n);
    #1;
    check($sformatf("%s.lat.ack", tag), 32'(bus.WB_ACK_O), 32'd0);
    check($sformatf("%s.lat.err", tag), 32'(bus.WB_ERR_O), 32'd0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k > 0) drive_beat(we_i, adr_i, idx, bte_i, sel_i, k, n);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s.rst.ack", tag), 32'(bus.WB_ACK_O), 32'd0);
        check($sformatf("%s.rst.err", tag), 32'(bus.WB_ERR_O), 32'd0);
        @(posedge clk); #1;
        rst_n        = 1'b1;
        bus.WB_CYC_I = 1'b0;
        bus.WB_STB_I = 1'b0;
        model_err    = 0;
        break;
      end
      #1;
      check($sformatf("%s.b%0d.ack", tag, k), 32'(bus.WB_ACK_O), 32'(hit));
      check($sformatf("%s.b%0d.err", tag, k), 32'(bus.WB_ERR_O), 32'(!hit));
      if (!we_i || !hit)
        check($sformatf("%s.b%0d.dat", tag, k), bus.WB_DAT_O, hit ? model_mem[idx] : 32'd0);
      rd_got[k] = bus.WB_DAT_O;
      if (hit && we_i) model_mem[idx] = (model_mem[idx] & ~mask) | (beat_dat[k] & mask);
      if (!hit && model_err < 65535) model_err++;
      idx = next_word(idx, bte_i);
      if (k == gap_after && k < n - 1) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          bus.WB_STB_I = 1'b0;
          #1;
          check($sformatf("%s.gap%0d.ack", tag, g), 32'(bus.WB_ACK_O), 32'd0);
          check($sformatf("%s.gap%0d.err", tag, g), 32'(bus.WB_ERR_O), 32'd0);
        end
      end
    end
    @(posedge clk); #1;
    bus.WB_CYC_I = 1'b0;
    bus.WB_STB_I = 1'b0;
    bus.WB_WE_I  = 1'b0;
    #1;
    check($sformatf("%s.idle.ack", tag), 32'(bus.WB_ACK_O), 32'd0);
    check($sformatf("%s.idle.err", tag), 32'(bus.WB_ERR_O), 32'd0);
    check($sformatf("%s.errcnt", tag), 32'(err_cnt), model_err);
  endtask

  initial begin
    logic [31:0] adr;
    int          n;
    rst_n        = 1'b0;
    bus.WB_CYC_I = 1'b0;
    bus.WB_STB_I = 1'b0;
    bus.WB_WE_I  = 1'b0;
    bus.WB_ADR_I = '0;
    bus.WB_DAT_I = '0;
    bus.WB_SEL_I = '0;
    bus.WB_CTI_I = '0;
    bus.WB_BTE_I = '0;
    model_err    = 0;

    repeat (2) @(posedge clk);
    #2;
    check("rst.ack", 32'(bus.WB_ACK_O), 32'd0);
    check("rst.err", 32'(bus.WB_ERR_O), 32'd0);
    check("rst.dat", bus.WB_DAT_O, 32'd0);
    check("rst.cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Give every word a known value with one linear burst over the whole memory.
    for (int i = 0; i < 256; i++) beat_dat[i] = $urandom;
    burst("fill", 1'b1, 32'h0, 2'd0, 4'hF, 256, -1, 0, -1);

    beat_dat[0] = 32'hDEAD_BEEF;
    burst("t1w", 1'b1, 32'h10, 2'd0, 4'hF, 1, -1, 0, -1);
    burst("t1r", 1'b0, 32'h10, 2'd0, 4'hF, 1, -1, 0, -1);
    check("t1.data", rd_got[0], 32'hDEAD_BEEF);

    for (int i = 0; i < 4; i++) beat_dat[i] = 32'(i + 1);
    burst("t2w", 1'b1, 32'h08, 2'd1, 4'hF, 4, -1, 0, -1);
    burst("t2r", 1'b0, 32'h08, 2'd1, 4'hF, 4, -1, 0, -1);
    for (int i = 0; i < 4; i++) check($sformatf("t2.data%0d", i), rd_got[i], 32'(i + 1));

    beat_dat[0] = 32'h1122_3344;
    burst("t3p", 1'b1, 32'h14, 2'd0, 4'hF, 1, -1, 0, -1);
    beat_dat[0] = 32'hAABB_CCDD;
    burst("t3w", 1'b1, 32'h14, 2'd0, 4'b0101, 1, -1, 0, -1);
    burst("t3r", 1'b0, 32'h14, 2'd0, 4'hF, 1, -1, 0, -1);
    check("t3.data", rd_got[0], 32'h11BB_33DD);

    burst("t4r", 1'b0, 32'h400, 2'd0, 4'hF, 1, -1, 0, -1);
    check("t4.cnt1", 32'(err_cnt), 32'd1);
    beat_dat[0] = 32'h5A5A_A5A5;
    burst("t4w", 1'b1, 32'h02, 2'd0, 4'hF, 1, -1, 0, -1);
    check("t4.cnt2", 32'(err_cnt), 32'd2);
    burst("t4chk", 1'b0, 32'h00, 2'd0, 4'hF, 1, -1, 0, -1);

    burst("t5", 1'b0, 32'h3F8, 2'd0, 4'hF, 4, 0, 2, -1);

    for (int i = 0; i < 4; i++) beat_dat[i] = $urandom;
    burst("t6w", 1'b1, 32'h40, 2'd0, 4'hF, 4, -1, 0, 2);
    check("t6.cnt", 32'(err_cnt), 32'd0);
    burst("t6r", 1'b0, 32'h40, 2'd0, 4'hF, 4, -1, 0, -1);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 9))
        0:       adr = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
        1:       adr = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        default: adr = {22'd0, 8'($urandom), 2'b00};
      endcase
      n = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 9));
      for (int i = 0; i < n; i++) beat_dat[i] = $urandom;
      burst($sformatf("rnd%0d", r), 1'($urandom), adr, 2'($urandom), 4'($urandom), n,
            int'($urandom_range(0, 8)), int'($urandom_range(1, 3)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
